// File: rtl/sdram_request_scheduler.sv
// sdram_request_scheduler: arbitrates NREQ requester FIFOs onto one EasySDRAM command port and routes read data back by tag
module sdram_request_scheduler #(
    parameter int NREQ          = 3,
    parameter int MAX_WAIT      = 64,
    parameter int TAG_DEPTH     = 16,
    parameter int REFRESH_GUARD = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_urgent,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*25-1:0]   req_addr,
    input  logic [NREQ*16-1:0]   req_wdata,
    input  logic [NREQ*2-1:0]    req_mask,
    output logic [NREQ-1:0]      req_ready,
    output logic                 cmd_write,
    input  logic                 cmd_full,
    output logic                 cmd_is_write,
    output logic [24:0]          cmd_address,
    output logic [15:0]          cmd_wdata,
    output logic [1:0]           cmd_mask,
    input  logic [9:0]           refresh_countdown,
    output logic                 keep_open,
    input  logic                 rd_valid,
    input  logic [15:0]          rd_data,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 err_orphan
);
    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(TAG_DEPTH);

    logic [IW-1:0]   rr_q, rr_d, gnt, idx;
    logic [14:0]     row_q, gnt_row;
    logic            row_valid_q, row_live, found, tag_full, push, pop, gnt_wr;
    logic [AW-1:0]   age_q [NREQ];
    logic [IW-1:0]   tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]   wp_q, rp_q;
    logic [TW:0]     cnt_q, cnt_d;
    logic [NREQ-1:0] elig, urg, stv, hit, cls, rsp_valid_q;
    logic [15:0]     rsp_data_q;
    logic            err_q;

    assign row_live  = refresh_countdown > 10'(REFRESH_GUARD);
    assign keep_open = row_valid_q & row_live;
    assign tag_full  = cnt_q == (TW+1)'(TAG_DEPTH);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign err_orphan = err_q;

    // Per-requester eligibility and the four priority classes; the highest non-empty one wins
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = rst & req_valid[i] & ~cmd_full & (req_write[i] | ~tag_full);
            urg[i]  = elig[i] & req_urgent[i];
            stv[i]  = elig[i] & (age_q[i] == AW'(MAX_WAIT));
            hit[i]  = elig[i] & keep_open & (req_addr[i*25+10 +: 15] == row_q);
        end
        cls = |urg ? urg : |stv ? stv : |hit ? hit : elig;
    end

    // Round-robin pick within the winning class, then mux the granted requester onto the command port
    always_comb begin
        found        = 1'b0;
        gnt          = '0;
        idx          = '0;
        cmd_is_write = 1'b0;
        cmd_address  = '0;
        cmd_wdata    = '0;
        cmd_mask     = '0;
        gnt_row      = '0;
        gnt_wr       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NREQ);
            if (!found && cls[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (found && gnt == IW'(i)) begin
                gnt_wr       = req_write[i];
                cmd_is_write = req_write[i];
                cmd_address  = req_addr[i*25 +: 25];
                cmd_wdata    = req_wdata[i*16 +: 16];
                cmd_mask     = req_mask[i*2 +: 2];
                gnt_row      = req_addr[i*25+10 +: 15];
            end
        end
        req_ready = found ? NREQ'(1) << gnt : '0;
        cmd_write = found;
        push      = found & ~gnt_wr;
        pop       = rd_valid & (cnt_q != '0);
        rr_d      = (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
        cnt_d     = cnt_q + (TW+1)'(push) - (TW+1)'(pop);
    end

    // Round-robin pointer and open-row tracking; a refresh approaching always drops the row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q        <= '0;
            row_q       <= '0;
            row_valid_q <= 1'b0;
        end else begin
            if (found) begin
                rr_q  <= rr_d;
                row_q <= gnt_row;
            end
            row_valid_q <= row_live & (row_valid_q | found);
        end
    end

    // Wait-age counters feeding the starvation class
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || req_ready[i]) age_q[i] <= '0;
                else if (age_q[i] != AW'(MAX_WAIT)) age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end

    // Tag storage: requester index of each outstanding read, in issue order
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wp_q] <= gnt;
    end

    // Tag FIFO pointers and the registered read response path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) begin
                rp_q       <= rp_q + 1'b1;
                rsp_data_q <= rd_data;
            end
            cnt_q       <= cnt_d;
            rsp_valid_q <= pop ? NREQ'(1) << tag_mem_q[rp_q] : '0;
            err_q       <= err_q | (rd_valid & (cnt_q == '0));
        end
    end
endmodule

// File: doc/sdram_request_scheduler.md
Name: sdram_request_scheduler

Overview:
- Shares the single EasySDRAM command interface among NREQ requester ports (camera write FIFO, VGA read FIFO, user ports).
- Each cycle, picks at most one request and forwards it as a command.
- Favours the open row, honours urgency and starvation limits, and routes read data back to the issuing requester through an in-order tag FIFO.
- Sits between the port FIFOs and EasySDRAM inside the SDRAM port wrapper.

Parameters:
NREQ, 3, number of requester ports (2..8)
MAX_WAIT, 64, cycles a valid, ungranted requester waits before it is starved
TAG_DEPTH, 16, maximum outstanding reads (power of 2)
REFRESH_GUARD, 50, refreshCountdown threshold at or below which the open row is considered lost

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  requester i has a command at its FIFO head (showahead)
req_urgent  in  NREQ  requester i FIFO is near full/empty threshold
req_write  in  NREQ  1=write, 0=read, per requester
req_addr  in  NREQ*25  word address, {bank,row,col}, row key = addr[24:10]
req_wdata  in  NREQ*16  write data
req_mask  in  NREQ*2  write byte mask
req_ready  out  NREQ  one-hot pop/grant, same cycle as issue
cmd_write  out  1  EasySDRAM write strobe
cmd_full  in  1  EasySDRAM command buffer full
cmd_is_write  out  1  command type
cmd_address  out  25  command address
cmd_wdata  out  16  command write data
cmd_mask  out  2  command write mask
refresh_countdown  in  10  EasySDRAM refresh countdown
keep_open  out  1  to EasySDRAM keepOpen
rd_valid  in  1  EasySDRAM read data valid
rd_data  in  16  EasySDRAM read data
rsp_valid  out  NREQ  one-hot read response strobe
rsp_data  out  16  read response data
err_orphan  out  1  sticky: rd_valid arrived with no outstanding tag

Behaviour:
- Reset (rst=0, async): req_ready=0, cmd_write=0, rsp_valid=0, rsp_data=0, err_orphan=0, keep_open=0. Internal state also clears: row_valid=0, rr_ptr=0, all age counters 0, tag FIFO empty.
- Issue path is combinational: cmd_write = |req_ready. cmd_* fields are muxed from the granted index and are 0 when there is no grant.
- Eligibility of requester i requires all of:
  - req_valid[i]=1
  - cmd_full=0
  - if a read: tag FIFO not full. A same-cycle tag pop does not free a slot for that cycle.
- Grant class priority, highest first:
  1. urgent: eligible with req_urgent=1
  2. starved: eligible with age==MAX_WAIT
  3. row-hit: eligible, row_valid=1, addr[24:10]==present_row
  4. any eligible
- Within the highest non-empty class, round-robin: first index at or after rr_ptr, wrapping modulo NREQ.
- On grant to index g:
  - rr_ptr <= (g+1) mod NREQ
  - present_row <= addr[24:10] of g; row_valid <= 1
  - if a read, push g into the tag FIFO
- Row invalidation: when refresh_countdown <= REFRESH_GUARD, row_valid <= 0 and class 3 is empty. A grant in the same cycle does not re-set row_valid.
- keep_open = row_valid && refresh_countdown > REFRESH_GUARD (combinational).
- Age counter i:
  - cleared when req_valid[i]=0 or when i is granted
  - otherwise +1 per cycle, saturating at MAX_WAIT
  - width clog2(MAX_WAIT+1)
- Read return:
  - On rd_valid with tag FIFO non-empty: pop head h. Next cycle rsp_valid[h]=1 for exactly one cycle, and rsp_data=rd_data is registered.
  - Consecutive rd_valid cycles give back-to-back responses.
  - On rd_valid with tag FIFO empty: no response; err_orphan <= 1 until reset.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- rsp_data holds its last value when rsp_valid=0.
- Reset mid-operation discards outstanding tags. Read data arriving after reset sets err_orphan.

Test Plan:
- Reset, then req_valid=3'b111, no urgent, row_valid=0 → grants 0, 1, 2, 0 on successive cycles; cmd_write=1 each cycle.
- Grant req0 at addr 0x0000400, then req1 at 0x0000800 and req2 at 0x0000401 both valid, rr_ptr=1 → req2 granted (row hit 0x001), then req1.
- cmd_full=1 for 5 cycles with all requesters valid → req_ready=0 throughout; age counters reach 5; no command issued.
- req0 valid but blocked behind req1 with a row hit for 64 cycles → on cycle 65, req0 is granted over the row hit. req_urgent[1]=1 then beats a starved req0.
- Issue 16 reads from req1 with rd_valid held off → 17th read blocked; writes from req0 still issue. rd_valid ×16 with data 0x0001..0x0010 → rsp_valid[1] 16 pulses, one cycle after each, data in order.
- rd_valid with the tag FIFO empty → err_orphan=1 and it stays high. refresh_countdown=50 → keep_open=0 and row-hit priority is disabled. Async rst low mid-burst → all outputs 0 immediately.
